// File: rtl/regex_cpu_multi_op.sv
// regex_cpu_multi_op: single-thread regex execution unit running the full opcode set
// over a character window, emitting successor threads through an output FIFO.
module regex_cpu_multi_op #(
    parameter int PC_WIDTH              = 8,
    parameter int CHARACTER_WIDTH       = 8,
    parameter int CC_ID_BITS            = 2,
    parameter int MEMORY_WIDTH          = 16,
    parameter int MEMORY_ADDR_WIDTH     = 11,
    parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]    current_characters,
    input  logic                                          input_pc_valid,
    input  logic [PC_WIDTH-1:0]                           input_pc,
    input  logic [CC_ID_BITS-1:0]                         input_cc_id,
    output logic                                          input_pc_ready,
    output logic                                          memory_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
    input  logic                                          memory_ready,
    input  logic [MEMORY_WIDTH-1:0]                       memory_data,
    output logic                                          output_pc_valid,
    output logic [PC_WIDTH-1:0]                           output_pc,
    output logic [CC_ID_BITS-1:0]                         output_cc_id,
    input  logic                                          output_pc_ready,
    output logic                                          accepts,
    output logic [CC_ID_BITS-1:0]                         accepted_cc_id,
    output logic                                          running,
    output logic [2**CC_ID_BITS-1:0]                      elaborating_chars
);
    localparam int SLOTS = 2**CC_ID_BITS;
    localparam int DEPTH = 2**FIFO_WIDTH_POWER_OF_2;
    localparam int CNT_W = FIFO_WIDTH_POWER_OF_2 + 1;
    localparam logic [2:0] OP_ACCEPT         = 3'd0;
    localparam logic [2:0] OP_SPLIT          = 3'd1;
    localparam logic [2:0] OP_MATCH          = 3'd2;
    localparam logic [2:0] OP_JMP            = 3'd3;
    localparam logic [2:0] OP_END            = 3'd4;
    localparam logic [2:0] OP_MATCH_ANY      = 3'd5;
    localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'd6;
    localparam logic [2:0] OP_NOT_MATCH      = 3'd7;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, EXEC2} state_t;
    state_t state, next;

    logic [PC_WIDTH-1:0]                pc, push_pc, t;
    logic [CC_ID_BITS-1:0]              cc, n, push_cc;
    logic [MEMORY_WIDTH-1:0]            instr;
    logic [CHARACTER_WIDTH-1:0]         c, ch;
    logic [2:0]                         op;
    logic                               push, pop, take;
    logic [PC_WIDTH-1:0]                fifo_pc [DEPTH];
    logic [CC_ID_BITS-1:0]              fifo_cc [DEPTH];
    logic [FIFO_WIDTH_POWER_OF_2-1:0]   wr, rd;
    logic [CNT_W-1:0]                   count;
    logic [CNT_W-1:0]                   slot_cnt [SLOTS];
    logic                               unused_instr;

    assign op              = instr[MEMORY_WIDTH-1 -: 3];
    assign t               = instr[PC_WIDTH-1:0];
    assign ch              = instr[CHARACTER_WIDTH-1:0];
    assign unused_instr    = ^instr;
    assign c               = current_characters[cc*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    assign n               = cc + CC_ID_BITS'(1);
    // Two slots are reserved at acceptance so a SPLIT can never overflow the FIFO.
    assign input_pc_ready  = state == IDLE && count <= CNT_W'(DEPTH - 2);
    assign take            = input_pc_valid && input_pc_ready;
    assign memory_valid    = state == FETCH;
    assign memory_addr     = MEMORY_ADDR_WIDTH'(pc);
    assign output_pc_valid = count != '0;
    assign output_pc       = output_pc_valid ? fifo_pc[rd] : '0;
    assign output_cc_id    = output_pc_valid ? fifo_cc[rd] : '0;
    assign pop             = output_pc_valid && output_pc_ready;
    assign running         = state != IDLE || output_pc_valid;
    assign accepted_cc_id  = accepts ? cc : '0;

    always_comb begin
        next    = state;
        push    = 1'b0;
        push_pc = pc + PC_WIDTH'(1);
        push_cc = n;
        accepts = 1'b0;
        case (state)
            IDLE:  next = take ? FETCH : IDLE;
            FETCH: next = memory_ready ? EXEC : FETCH;
            EXEC: begin
                next = IDLE;
                case (op)
                    OP_MATCH:          push = c == ch;
                    OP_NOT_MATCH:      push = c != ch;
                    OP_MATCH_ANY:      push = 1'b1;
                    OP_JMP: begin
                        push    = 1'b1;
                        push_pc = t;
                        push_cc = cc;
                    end
                    OP_SPLIT: begin
                        push    = 1'b1;
                        push_cc = cc;
                        next    = EXEC2;
                    end
                    OP_ACCEPT:         accepts = c == '0;
                    OP_ACCEPT_PARTIAL: accepts = 1'b1;
                    default:           push = 1'b0;
                endcase
            end
            EXEC2: begin
                push    = 1'b1;
                push_pc = t;
                push_cc = cc;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= '0;
            cc    <= '0;
            instr <= '0;
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            for (int i = 0; i < SLOTS; i++) slot_cnt[i] <= '0;
        end else begin
            state <= next;
            if (take) begin
                pc <= input_pc;
                cc <= input_cc_id;
            end
            if (state == FETCH && memory_ready) instr <= memory_data;
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            for (int i = 0; i < SLOTS; i++)
                slot_cnt[i] <= slot_cnt[i] + CNT_W'(push && push_cc == CC_ID_BITS'(i))
                                           - CNT_W'(pop && output_cc_id == CC_ID_BITS'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr] <= push_pc;
            fifo_cc[wr] <= push_cc;
        end
    end

    always_comb begin
        elaborating_chars = '0;
        for (int i = 0; i < SLOTS; i++)
            elaborating_chars[i] = slot_cnt[i] != '0 || (state != IDLE && cc == CC_ID_BITS'(i));
    end
endmodule
